// File: rtl/invaders_mem_pkg.sv
// Shared types and constants for the Invaders work/video RAM sequencing logic.
package invaders_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } arb_gnt_e;

  localparam logic [2:0] CPU_RAM_BASE_HI  = 3'b001;
  localparam int         STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/invaders_ram_clear.sv
// Zero-fill address counter: steps through every RAM word while enabled and
// flags the final address so the arbiter can leave its clear phase.
module invaders_ram_clear #(
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign addr_o = cnt_q;
  assign done_o = en_i && (cnt_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/invaders_ram_arbiter.sv
// Shared work/video RAM sequencer: zero-fills after reset, then arbitrates one
// RAM access per cycle between CPU and video. INVADERS_ARB_STATS_EN adds a stall counter.
module invaders_ram_arbiter
  import invaders_mem_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [15:0]       cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic              vid_overrun_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_q_i,
`ifdef INVADERS_ARB_STATS_EN
  output logic [15:0]       cpu_stall_cnt_o,
`endif
  output logic              clear_busy_o
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e        state_q;
  arb_gnt_e          gnt;
  logic              busy_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        starve_q;
  logic              cpu_ack_q, cpu_rd_q, vid_valid_q, overrun_q;
  logic              clr_en, clr_done, run;
  logic [ADDR_W-1:0] clr_addr;
  logic              cpu_in_win, cpu_live, vid_cand, cpu_wr_issue;
  logic [ADDR_W-1:0] vid_cand_addr;

  // Reset is folded in so nothing reaches the RAM while it is held.
  assign clr_en = (state_q == CLEAR) && !rst_i;
  assign run    = (state_q == RUN) && !rst_i;

  invaders_ram_clear #(.ADDR_W(ADDR_W)) u_clear (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (clr_en),
    .addr_o (clr_addr),
    .done_o (clr_done)
  );

  assign cpu_in_win    = (cpu_addr_i[15:13] == CPU_RAM_BASE_HI);
  // The ack cycle never re-issues the same request.
  assign cpu_live      = run && cpu_req_i && !cpu_ack_q;
  assign vid_cand      = run && (pend_q || vid_req_i);
  assign vid_cand_addr = pend_q ? pend_addr_q : vid_addr_i;

  always_comb begin
    gnt = GNT_NONE;
    if (cpu_live && cpu_in_win && (!vid_cand || starve_q == STARVE_MAX)) begin
      gnt = GNT_CPU;
    end else if (vid_cand) begin
      gnt = GNT_VID;
    end
    ram_addr_d = ram_addr_q;
    if (clr_en) begin
      ram_addr_d = clr_addr;
    end else if (gnt == GNT_CPU) begin
      ram_addr_d = cpu_addr_i[ADDR_W-1:0];
    end else if (gnt == GNT_VID) begin
      ram_addr_d = vid_cand_addr;
    end
  end

  assign cpu_wr_issue = (gnt == GNT_CPU) && cpu_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CLEAR;
      busy_q      <= 1'b1;
      pend_q      <= 1'b0;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      ram_addr_q  <= '0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      cpu_ack_q   <= (gnt == GNT_CPU) || (cpu_live && !cpu_in_win);
      cpu_rd_q    <= (gnt == GNT_CPU) && !cpu_we_i;
      vid_valid_q <= (gnt == GNT_VID);
      case (state_q)
        CLEAR: begin
          if (clr_done) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          // A displaced fetch parks in the single pending slot; a second one is lost.
          if (gnt == GNT_CPU && vid_cand) begin
            if (!pend_q) begin
              pend_q      <= 1'b1;
              pend_addr_q <= vid_addr_i;
            end else if (vid_req_i) begin
              overrun_q <= 1'b1;
            end
          end else if (gnt == GNT_VID && pend_q) begin
            pend_q      <= vid_req_i;
            pend_addr_q <= vid_addr_i;
          end
          if (!cpu_req_i || gnt == GNT_CPU) begin
            starve_q <= '0;
          end else if (cpu_live && cpu_in_win && gnt == GNT_VID) begin
            starve_q <= starve_q + 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign ram_we_o      = clr_en || cpu_wr_issue;
  assign ram_wdata_o   = cpu_wr_issue ? cpu_wdata_i : '0;
  assign ram_addr_o    = ram_addr_d;
  assign cpu_ack_o     = cpu_ack_q;
  assign cpu_rdata_o   = cpu_rd_q ? ram_q_i : '0;
  assign vid_valid_o   = vid_valid_q;
  assign vid_rdata_o   = vid_valid_q ? ram_q_i : '0;
  assign vid_overrun_o = overrun_q;
  assign clear_busy_o  = busy_q;

`ifdef INVADERS_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (run && cpu_req_i && gnt != GNT_CPU && !(cpu_live && !cpu_in_win)
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign cpu_stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_invaders_ram_arbiter.sv
// Self-checking bench for invaders_ram_arbiter: directed scenarios plus random
// CPU/video traffic against a cycle-level reference model of the access rules.
module tb_invaders_ram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int LIMIT  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cpu_req, cpu_we, cpu_ack, vid_req, vid_valid, vid_overrun;
  logic              ram_we, clear_busy;
  logic [15:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, vid_rdata, ram_wdata, ram_q;
  logic [ADDR_W-1:0] vid_addr, ram_addr;

  invaders_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_valid_o(vid_valid),
    .vid_rdata_o(vid_rdata), .vid_overrun_o(vid_overrun),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we), .ram_q_i(ram_q),
    .clear_busy_o(clear_busy)
  );

  // Single-port RAM with synchronous read; scramble preloads garbage.
  logic [DATA_W-1:0] mem [DEPTH];
  logic scramble;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'($urandom);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sampled DUT outputs.
  int s_we, s_addr, s_wdata, s_ack, s_rdata, s_vvalid, s_vrdata, s_ovr, s_busy;

  // Reference model state.
  int m_valid = 0;
  int m_busy, m_idx, m_starve, m_ack, m_rdata, m_vvalid, m_vrdata, m_ovr, m_last;
  int m_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  // One clock cycle: inputs were set by the caller; sample at negedge, check,
  // advance the model, and return just after the next rising edge.
  task automatic step();
    int e_we, e_addr, e_wdata, cand, n_ack, n_rdata, n_vvalid, n_vrdata;
    bit in_win, cpu_wants, have_cand, cpu_wins;
    @(negedge clk);
    s_we = int'(ram_we); s_addr = int'(ram_addr); s_wdata = int'(ram_wdata);
    s_ack = int'(cpu_ack); s_rdata = int'(cpu_rdata); s_vvalid = int'(vid_valid);
    s_vrdata = int'(vid_rdata); s_ovr = int'(vid_overrun); s_busy = int'(clear_busy);
    e_we = 0; e_addr = m_last; e_wdata = 0;
    n_ack = 0; n_rdata = 0; n_vvalid = 0; n_vrdata = 0;
    if (m_valid != 0) begin
      chk("clear_busy", s_busy, m_busy);
      chk("cpu_ack", s_ack, m_ack);
      if (m_ack != 0) chk("cpu_rdata", s_rdata, m_rdata);
      chk("vid_valid", s_vvalid, m_vvalid);
      if (m_vvalid != 0) chk("vid_rdata", s_vrdata, m_vrdata);
      chk("vid_overrun", s_ovr, m_ovr);
    end
    if (rst) begin
      if (m_valid != 0) begin
        chk("ram_we", s_we, 0);
        chk("ram_addr", s_addr, e_addr);
      end
      m_valid = 1; m_busy = 1; m_idx = 0; m_starve = 0; m_ovr = 0; m_last = 0;
      m_q.delete();
    end else if (m_valid != 0) begin
      if (m_busy != 0) begin
        e_we = 1; e_addr = m_idx;
        ref_mem[m_idx] = '0;
        m_idx++;
        if (m_idx == DEPTH) begin m_busy = 0; m_idx = 0; end
      end else begin
        in_win    = (cpu_addr[15:13] == 3'b001);
        cpu_wants = cpu_req && (m_ack == 0);
        have_cand = (m_q.size() > 0) || vid_req;
        cand      = (m_q.size() > 0) ? m_q[0] : int'(vid_addr);
        cpu_wins  = cpu_wants && in_win && (!have_cand || m_starve == LIMIT);
        n_ack     = int'(cpu_wants && (cpu_wins || !in_win));
        if (cpu_wins) begin
          e_addr = int'(cpu_addr[ADDR_W-1:0]);
          e_we = int'(cpu_we);
          if (cpu_we) begin
            e_wdata = int'(cpu_wdata);
            ref_mem[e_addr] = cpu_wdata;
          end else begin
            n_rdata = int'(ref_mem[e_addr]);
          end
        end else if (have_cand) begin
          e_addr = cand; n_vvalid = 1; n_vrdata = int'(ref_mem[cand]);
        end
        if (have_cand) begin
          if (cpu_wins) begin
            if (m_q.size() == 0) m_q.push_back(int'(vid_addr));
            else if (vid_req) m_ovr = 1;
          end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (vid_req) m_q.push_back(int'(vid_addr));
          end
        end
        if (!cpu_req || cpu_wins) m_starve = 0;
        else if (cpu_wants && in_win && have_cand) m_starve++;
      end
      chk("ram_we", s_we, e_we);
      chk("ram_addr", s_addr, e_addr);
      if (e_we != 0) chk("ram_wdata", s_wdata, e_wdata);
      m_last = e_addr;
    end
    m_ack = n_ack; m_rdata = n_rdata; m_vvalid = n_vvalid; m_vrdata = n_vrdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 0; vid_req = 0;
    repeat (n) step();
  endtask

  task automatic run_clear(output int busy_cycles, output int acks, output int first_addr);
    busy_cycles = 0; acks = 0; first_addr = -1;
    for (int i = 0; i < DEPTH + 100; i++) begin
      step();
      if (i == 0) first_addr = s_addr;
      if (s_ack != 0) acks++;
      if (s_busy == 0) break;
      busy_cycles++;
    end
  endtask

  task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d,
                            output int lat, output int rdata, output int f_we, output int f_addr);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; lat = 0;
    step();
    f_we = s_we; f_addr = s_addr;
    do begin
      step();
      lat++;
    end while (s_ack == 0 && lat < 50);
    rdata = s_rdata;
    cpu_req = 0;
  endtask

  initial begin
    #1_000_000;
    chk("watchdog_expired", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int busy, acks, faddr, lat, rd, fwe, fad, issue_idx, n;
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0; scramble = 1;
    @(posedge clk); #1;
    scramble = 0;
    step(); step();
    chk("rst_cpu_ack", s_ack, 0);
    chk("rst_cpu_rdata", s_rdata, 0);
    chk("rst_vid_valid", s_vvalid, 0);
    chk("rst_vid_rdata", s_vrdata, 0);
    chk("rst_overrun", s_ovr, 0);
    chk("rst_clear_busy", s_busy, 1);
    chk("rst_ram_we", s_we, 0);
    chk("rst_ram_addr", s_addr, 0);

    rst = 0;
    run_clear(busy, acks, faddr);
    chk("clear_cycles", busy, DEPTH);
    chk("clear_first_addr", faddr, 0);

    cpu_access(1'b0, 16'h2ABC, 8'h00, lat, rd, fwe, fad);
    chk("rd_2abc_latency", lat, 1);
    chk("rd_2abc_issue_addr", fad, 'h0ABC);
    chk("rd_2abc_data", rd, 0);

    cpu_access(1'b1, 16'h2400, 8'h5A, lat, rd, fwe, fad);
    chk("wr_2400_we", fwe, 1);
    chk("wr_2400_addr", fad, 'h0400);
    chk("wr_2400_latency", lat, 1);
    cpu_access(1'b0, 16'h2400, 8'h00, lat, rd, fwe, fad);
    chk("rd_2400_data", rd, 'h5A);

    cpu_access(1'b0, 16'h0100, 8'h00, lat, rd, fwe, fad);
    chk("oow_we", fwe, 0);
    chk("oow_addr_held", fad, 'h0400);
    chk("oow_latency", lat, 1);
    chk("oow_rdata", rd, 0);
    idle(2);

    // Starvation: CPU held, video strobing every cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2010; issue_idx = -1;
    for (int i = 0; i < 20 && issue_idx < 0; i++) begin
      vid_req = 1; vid_addr = 13'(13'h1000 + i);
      step();
      if (s_addr == 'h0010) issue_idx = i;
    end
    chk("starve_issue_cycle", issue_idx, LIMIT);
    vid_addr = 13'h1100;
    step();
    chk("starve_displaced_served", s_addr, 'h1000 + LIMIT);
    chk("starve_cpu_ack", s_ack, 1);
    n = 0;
    while (s_ovr == 0 && n < 40) begin
      vid_addr = 13'(13'h1200 + n);
      step();
      n++;
    end
    chk("starve_overrun_set", s_ovr, 1);

    // Reset while a CPU read waits; overrun must clear, no ack may appear.
    vid_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2000; rst = 1;
    step(); step();
    chk("rst2_cpu_ack", s_ack, 0);
    chk("rst2_overrun", s_ovr, 0);
    chk("rst2_vid_valid", s_vvalid, 0);
    chk("rst2_clear_busy", s_busy, 1);
    chk("rst2_ram_we", s_we, 0);
    rst = 0;
    run_clear(busy, acks, faddr);
    chk("rst2_clear_cycles", busy, DEPTH);
    chk("rst2_no_ack_in_clear", acks, 0);
    n = 0;
    while (s_ack == 0 && n < 5) begin step(); n++; end
    chk("rst2_cpu_served_after_clear", s_ack, 1);
    chk("rst2_cpu_rdata", s_rdata, 0);
    cpu_req = 0;

    // Reset in the middle of a clear restarts from address 0.
    rst = 1; step(); rst = 0;
    n = 0;
    do begin step(); n++; end while (!(s_addr == 'h0800 && s_busy == 1) && n < 3000);
    chk("midclear_reached_0800", s_addr, 'h0800);
    rst = 1; step(); rst = 0;
    run_clear(busy, acks, faddr);
    chk("midclear_restart_addr", faddr, 0);
    chk("midclear_cycles", busy, DEPTH);

    // Simultaneous start: video first, CPU the cycle after.
    cpu_access(1'b1, 16'h2100, 8'h77, lat, rd, fwe, fad);
    idle(2);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2100; vid_req = 1; vid_addr = 13'h0055;
    step();
    chk("sim_vid_issue_addr", s_addr, 'h0055);
    chk("sim_vid_issue_we", s_we, 0);
    vid_req = 0;
    step();
    chk("sim_vid_valid", s_vvalid, 1);
    chk("sim_cpu_issue_addr", s_addr, 'h0100);
    chk("sim_no_early_ack", s_ack, 0);
    step();
    chk("sim_cpu_ack", s_ack, 1);
    chk("sim_cpu_rdata", s_rdata, 'h77);
    idle(2);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if (s_ack != 0) cpu_req = 0;
      if (!cpu_req && $urandom_range(0, 3) != 0) begin
        cpu_req = 1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h4000, 16'hFFFF))
                                                : 16'(16'h2000 + $urandom_range(0, 63));
        cpu_wdata = 8'($urandom);
      end
      vid_req = 1'($urandom_range(0, 1));
      vid_addr = 13'($urandom_range(0, 63));
      step();
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
